// File: rtl/risc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : risc_sequencer
// Brief    : 8-phase instruction sequencer for the 8-bit RISC core; drives
//            fetch/execute strobes from phase, opcode and the zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module risc_sequencer #(
    parameter int PHASES = 8,
    parameter int OPW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic [2:0]     phase,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           wr,
    output logic           data_e,
    output logic           halt
);

    localparam logic [2:0] c_LAST_PHASE = 3'(PHASES - 1);

    localparam logic [OPW-1:0] c_OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] c_OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] c_OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] c_OP_AND = OPW'(3);
    localparam logic [OPW-1:0] c_OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] c_OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] c_OP_STO = OPW'(6);
    localparam logic [OPW-1:0] c_OP_JMP = OPW'(7);

    localparam logic [2:0] c_PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] c_PH_INST_FETCH = 3'd1;
    localparam logic [2:0] c_PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] c_PH_IDLE       = 3'd3;
    localparam logic [2:0] c_PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] c_PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] c_PH_ALU_OP     = 3'd6;
    localparam logic [2:0] c_PH_STORE      = 3'd7;

    logic [2:0] r_phase;
    logic       r_halted;

    logic w_aluop;
    logic w_hlt_now;
    logic w_sel;
    logic w_rd;
    logic w_ld_ir;
    logic w_inc_pc;
    logic w_ld_pc;
    logic w_ld_ac;
    logic w_wr;
    logic w_data_e;

    assign w_aluop   = (opcode == c_OP_ADD) || (opcode == c_OP_AND) ||
                       (opcode == c_OP_XOR) || (opcode == c_OP_LDA);
    assign w_hlt_now = (r_phase == c_PH_OP_ADDR) && (opcode == c_OP_HLT);

    // Halt capture is independent of enable; the phase freezes once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase  <= c_PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            if (enable && !r_halted) begin
                r_phase <= (r_phase == c_LAST_PHASE) ? c_PH_INST_ADDR : r_phase + 3'd1;
            end
            if (w_hlt_now) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_inc_pc = 1'b0;
        w_ld_pc  = 1'b0;
        w_ld_ac  = 1'b0;
        w_wr     = 1'b0;
        w_data_e = 1'b0;
        case (r_phase)
            c_PH_INST_ADDR: begin
                w_sel = 1'b1;
            end
            c_PH_INST_FETCH: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            c_PH_INST_LOAD, c_PH_IDLE: begin
                w_sel   = 1'b1;
                w_rd    = 1'b1;
                w_ld_ir = 1'b1;
            end
            c_PH_OP_ADDR: begin
                w_inc_pc = 1'b1;
            end
            c_PH_OP_FETCH: begin
                w_rd = w_aluop;
            end
            c_PH_ALU_OP: begin
                w_rd     = w_aluop;
                w_inc_pc = (opcode == c_OP_SKZ) && zero;
                w_ld_pc  = (opcode == c_OP_JMP);
                w_data_e = (opcode == c_OP_STO);
            end
            c_PH_STORE: begin
                w_rd     = w_aluop;
                w_ld_ac  = w_aluop;
                w_ld_pc  = (opcode == c_OP_JMP);
                w_wr     = (opcode == c_OP_STO);
                w_data_e = (opcode == c_OP_STO);
            end
            default: begin
                w_sel = 1'b0;
            end
        endcase
    end

    // A halted core must not touch memory, PC or accumulator.
    assign phase  = r_phase;
    assign halt   = r_halted || w_hlt_now;
    assign sel    = w_sel    && !r_halted;
    assign rd     = w_rd     && !r_halted;
    assign ld_ir  = w_ld_ir  && !r_halted;
    assign inc_pc = w_inc_pc && !r_halted;
    assign ld_pc  = w_ld_pc  && !r_halted;
    assign ld_ac  = w_ld_ac  && !r_halted;
    assign wr     = w_wr     && !r_halted;
    assign data_e = w_data_e && !r_halted;

endmodule
`default_nettype wire

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- 8-phase instruction sequencer for the 8-bit RISC core.
- Drives the load and enable strobes of the neighbouring `register` instances (instruction register, accumulator), the program counter and the memory/bus.
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Sits directly upstream of the register stage: its `ld_ir`/`ld_ac` outputs are the `load` inputs of those registers.

Parameters:
- PHASES, 8, number of phases per instruction cycle; fixed at 8, because the decode table below is defined for exactly 8 phases.
- OPW, 3, opcode width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
- enable  input  1  1 = advance phase each clock; 0 = hold phase (stall).
- opcode  input  OPW  current instruction opcode from the instruction register.
- zero  input  1  accumulator-is-zero flag.
- phase  output  3  current phase number, 0..7.
- sel  output  1  address mux select: 1 = PC address, 0 = IR operand address.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load (jump).
- ld_ac  output  1  accumulator load.
- wr  output  1  memory write strobe.
- data_e  output  1  accumulator-to-bus drive enable.
- halt  output  1  processor halted; sticky.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = opcode in {ADD, AND, XOR, LDA}.
- State consists of a 3-bit phase register and a 1-bit halted flag.
- Reset (rst=0, asynchronous): phase=0, halted=0. Resulting outputs: sel=1; rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e and halt all 0.
- Phase advance:
  - Each rising clk edge with rst=1, enable=1 and halted=0: phase <= phase+1, wrapping 7 -> 0.
  - enable=0 or halted=1: phase holds.
- Halt:
  - At a rising edge where phase=4 and opcode=HLT, halted <= 1. Phase also advances on that same edge, to 5, then freezes.
  - After that, halted stays 1 and phase stays frozen until reset. Only rst clears halted.
- Output decode is combinational from phase, opcode and zero. It is valid in the same cycle; no extra latency. Outputs not listed for a phase are 0.
  - Phase 0 (inst_addr): sel=1.
  - Phase 1 (inst_fetch): sel=1, rd=1.
  - Phase 2 (inst_load): sel=1, rd=1, ld_ir=1.
  - Phase 3 (idle): sel=1, rd=1, ld_ir=1.
  - Phase 4 (op_addr): inc_pc=1. halt=1 if opcode=HLT.
  - Phase 5 (op_fetch): rd=ALUOP.
  - Phase 6 (alu_op): rd=ALUOP; inc_pc=(opcode=SKZ && zero); ld_pc=(opcode=JMP); data_e=(opcode=STO).
  - Phase 7 (store): rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode=JMP); wr=(opcode=STO); data_e=(opcode=STO).
- halt output = (halted=1) OR (phase=4 && opcode=HLT).
- When halted=1, every output other than `halt` and `phase` is forced to 0.
- enable=0 mid-instruction: outputs keep decoding the held phase. The bench must not assume the strobes are suppressed during a stall.
- Reset mid-instruction (any phase, including halted): within the same cycle, phase returns to 0, halted clears and outputs return to their reset values.
- `opcode` and `zero` must be stable from phase 4 onward. A change during phases 0-3 affects only the outputs defined above for those phases.

Test Plan:
- Reset: rst=0 in phase 5 with opcode=STO -> phase=0, sel=1, and wr, data_e, halt all 0 with no clock edge. Release rst -> phase=1 after the next edge.
- ADD cycle: opcode=2, enable=1 for 8 clocks -> rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2,3; inc_pc=1 in phase 4; ld_ac=1 in phase 7 only; phase wraps 7 -> 0.
- SKZ: opcode=1 with zero=1 -> inc_pc=1 in phases 4 and 6. Same with zero=0 -> inc_pc=1 in phase 4 only.
- STO/JMP: opcode=6 -> data_e=1 in phases 6,7, wr=1 in phase 7, rd=0 in phases 5-7. opcode=7 -> ld_pc=1 in phases 6,7.
- HLT: opcode=0 -> halt=1 in phase 4. After the edge, phase=5 and stays 5 for 10 further clocks with halt=1 and all other strobes 0. rst pulse -> halt=0, phase=0.
- Stall: enable=0 for 3 clocks in phase 3 -> phase stays 3 with ld_ir=1. Re-enable -> phase 4 on the next edge.
